// File: rtl/cpu_pkg.sv
// Shared encodings for the CPU control sequencer: states, opcodes, mux selects and trap causes.
package cpu_pkg;

  typedef enum logic [2:0] {
    StFetch     = 3'd0,
    StDecode    = 3'd1,
    StExecute   = 3'd2,
    StMem       = 3'd3,
    StWriteback = 3'd4,
    StTrap      = 3'd5
  } state_t;

  // Instruction class resolved in DECODE and carried through the rest of the instruction.
  typedef enum logic [3:0] {
    ClsIllegal,
    ClsEcall,
    ClsEbreak,
    ClsBranch,
    ClsFence,
    ClsLoad,
    ClsStore,
    ClsAlu,
    ClsJump,
    ClsCsr
  } cls_t;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpFence  = 7'b0001111;
  localparam logic [6:0] OpOp     = 7'b0110011;
  localparam logic [6:0] OpOpImm  = 7'b0010011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpSystem = 7'b1110011;

  localparam logic [1:0] PcPlus4  = 2'd0;
  localparam logic [1:0] PcTarget = 2'd1;
  localparam logic [1:0] PcTrap   = 2'd2;

  localparam logic [1:0] RfAlu = 2'd0;
  localparam logic [1:0] RfMem = 2'd1;
  localparam logic [1:0] RfPc4 = 2'd2;
  localparam logic [1:0] RfCsr = 2'd3;

  localparam logic [1:0] CauseIllegal = 2'd0;
  localparam logic [1:0] CauseEcall   = 2'd1;
  localparam logic [1:0] CauseEbreak  = 2'd2;
  localparam logic [1:0] CauseBus     = 2'd3;

  localparam logic [1:0] SizeWord = 2'b11;

  function automatic cls_t classify(input logic [6:0] op_code, input logic [2:0] func3,
                                    input logic [1:0] read, input logic [1:0] write,
                                    input logic external_call, input logic external_break);
    cls_t cls;
    cls = ClsIllegal;
    case (op_code)
      OpBranch: cls = ClsBranch;
      OpFence:  cls = ClsFence;
      OpLoad:   cls = (read != 2'b00) ? ClsLoad : ClsIllegal;
      OpStore:  cls = (write != 2'b00) ? ClsStore : ClsIllegal;
      OpOp, OpOpImm, OpLui, OpAuipc: cls = ClsAlu;
      OpJal, OpJalr: cls = ClsJump;
      OpSystem: begin
        if (func3 == 3'b000) begin
          if (external_call)       cls = ClsEcall;
          else if (external_break) cls = ClsEbreak;
          else                     cls = ClsIllegal;
        end else if (func3 == 3'b100) begin
          cls = ClsIllegal;
        end else begin
          cls = ClsCsr;
        end
      end
      default: cls = ClsIllegal;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/cpu_sequencer.sv
// Multi-cycle control sequencer: fetch/decode/execute/mem/writeback with trap and bus timeout.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [6:0] op_code,
  input  logic [2:0] func3,
  input  logic [1:0] read,
  input  logic [1:0] write,
  input  logic       external_call,
  input  logic       external_break,
  input  logic       branch_taken,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic [1:0] mem_size,
  output logic       mem_addr_sel,
  output logic       ir_load,
  output logic       pc_write,
  output logic [1:0] pc_sel,
  output logic       rf_write,
  output logic [1:0] rf_src,
  output logic       csr_write,
  output logic       trap,
  output logic [1:0] trap_cause,
  output logic [2:0] state
);

  localparam int unsigned CntW = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

  state_t          state_q;
  cls_t            cls_q;
  logic [1:0]      size_q;
  logic [1:0]      cause_q;
  logic [CntW-1:0] cnt_q;
  logic            run_q;
  logic            timeout;

  // The last permitted wait cycle without mem_ready is the one that trips the trap.
  assign timeout = !mem_ready && (cnt_q == CntW'(MEM_TIMEOUT - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StFetch;
      cls_q   <= ClsIllegal;
      size_q  <= 2'b00;
      cause_q <= CauseIllegal;
      cnt_q   <= '0;
      run_q   <= 1'b0;
    end else begin
      // Holds off the first fetch until the first edge after reset release.
      run_q <= 1'b1;
      unique case (state_q)
        StFetch: begin
          if (run_q) begin
            if (mem_ready) begin
              state_q <= StDecode;
            end else if (timeout) begin
              state_q <= StTrap;
              cause_q <= CauseBus;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        StDecode: begin
          cls_q   <= classify(op_code, func3, read, write, external_call, external_break);
          size_q  <= (op_code == OpStore) ? write : read;
          state_q <= StExecute;
        end
        StExecute: begin
          unique case (cls_q)
            ClsBranch, ClsFence: begin
              state_q <= StFetch;
              cnt_q   <= '0;
            end
            ClsLoad, ClsStore: begin
              state_q <= StMem;
              cnt_q   <= '0;
            end
            ClsAlu, ClsJump, ClsCsr: state_q <= StWriteback;
            ClsEcall: begin
              state_q <= StTrap;
              cause_q <= CauseEcall;
            end
            ClsEbreak: begin
              state_q <= StTrap;
              cause_q <= CauseEbreak;
            end
            default: begin
              state_q <= StTrap;
              cause_q <= CauseIllegal;
            end
          endcase
        end
        StMem: begin
          if (mem_ready) begin
            if (cls_q == ClsLoad) begin
              state_q <= StWriteback;
            end else begin
              state_q <= StFetch;
              cnt_q   <= '0;
            end
          end else if (timeout) begin
            state_q <= StTrap;
            cause_q <= CauseBus;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StWriteback, StTrap: begin
          state_q <= StFetch;
          cnt_q   <= '0;
        end
        default: begin
          state_q <= StFetch;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // Moore decodes of state; ir_load, branch pc_sel and store completion also follow inputs.
  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_size     = 2'b00;
    mem_addr_sel = 1'b0;
    ir_load      = 1'b0;
    pc_write     = 1'b0;
    pc_sel       = PcPlus4;
    rf_write     = 1'b0;
    rf_src       = RfAlu;
    csr_write    = 1'b0;
    trap         = 1'b0;
    unique case (state_q)
      StFetch: begin
        if (run_q) begin
          mem_req  = 1'b1;
          mem_size = SizeWord;
          ir_load  = mem_ready;
        end
      end
      StExecute: begin
        if (cls_q == ClsBranch) begin
          pc_write = 1'b1;
          pc_sel   = branch_taken ? PcTarget : PcPlus4;
        end else if (cls_q == ClsFence) begin
          pc_write = 1'b1;
        end
      end
      StMem: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = (cls_q == ClsStore);
        mem_size     = size_q;
        pc_write     = mem_ready && (cls_q == ClsStore);
      end
      StWriteback: begin
        rf_write  = 1'b1;
        csr_write = (cls_q == ClsCsr);
        pc_write  = 1'b1;
        pc_sel    = (cls_q == ClsJump) ? PcTarget : PcPlus4;
        unique case (cls_q)
          ClsLoad: rf_src = RfMem;
          ClsJump: rf_src = RfPc4;
          ClsCsr:  rf_src = RfCsr;
          default: rf_src = RfAlu;
        endcase
      end
      StTrap: begin
        trap     = 1'b1;
        pc_write = 1'b1;
        pc_sel   = PcTrap;
      end
      default: ;
    endcase
  end

  assign trap_cause = cause_q;
  assign state      = state_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: stimulus queues expected retire/memory records, monitor checks.
module tb_cpu_sequencer;
  import cpu_pkg::*;

  localparam int unsigned TO = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] op_code = '0;
  logic [2:0] func3 = '0;
  logic [1:0] read = '0;
  logic [1:0] write = '0;
  logic       external_call = 1'b0;
  logic       external_break = 1'b0;
  logic       branch_taken = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_we, mem_addr_sel, ir_load, pc_write, rf_write, csr_write, trap;
  logic [1:0] mem_size, pc_sel, rf_src, trap_cause;
  logic [2:0] state;

  always #5 clock = ~clock;

  cpu_sequencer #(.MEM_TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .op_code(op_code), .func3(func3), .read(read),
    .write(write), .external_call(external_call), .external_break(external_break),
    .branch_taken(branch_taken), .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
    .mem_size(mem_size), .mem_addr_sel(mem_addr_sel), .ir_load(ir_load), .pc_write(pc_write),
    .pc_sel(pc_sel), .rf_write(rf_write), .rf_src(rf_src), .csr_write(csr_write),
    .trap(trap), .trap_cause(trap_cause), .state(state)
  );

  typedef struct packed {
    logic [1:0] pc_sel;
    logic       rf_write;
    logic [1:0] rf_src;
    logic       csr_write;
    logic       trap;
    logic [1:0] cause;
    logic [2:0] st;
  } pc_exp_t;

  typedef struct packed {
    logic       we;
    logic       sel;
    logic [1:0] size;
    logic       ir;
  } mem_exp_t;

  pc_exp_t  pc_q[$];
  mem_exp_t mem_q[$];
  int       checks = 0;
  int       failures = 0;
  logic [1:0] hc = 2'd0;
  string    cur_name = "reset";
  pc_exp_t  mon_pc;
  mem_exp_t mon_mem;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic pc_exp_t ret(input logic [1:0] ps, input logic rf, input logic [1:0] src,
                                  input logic csr, input logic [2:0] st);
    pc_exp_t e;
    e.pc_sel = ps; e.rf_write = rf; e.rf_src = src; e.csr_write = csr;
    e.trap = 1'b0; e.cause = hc; e.st = st;
    return e;
  endfunction

  function automatic pc_exp_t trp(input logic [1:0] c);
    pc_exp_t e;
    hc = c;
    e.pc_sel = PcTrap; e.rf_write = 1'b0; e.rf_src = 2'd0; e.csr_write = 1'b0;
    e.trap = 1'b1; e.cause = c; e.st = 3'd5;
    return e;
  endfunction

  // Drives one instruction; memory answers after flat/dlat wait cycles, noise drives idle ready.
  task automatic run_instr(input string nm, input logic [6:0] op, input logic [2:0] f3,
                           input logic [1:0] rd, input logic [1:0] wr, input logic ec,
                           input logic eb, input logic tk, input int flat, input int dlat,
                           input logic noise, input pc_exp_t e, input logic dmem,
                           input logic dwe, input logic [1:0] dsz,
                           output int cycles, output int fcyc, output int dcyc);
    int age;
    bit done;
    mem_exp_t m;
    cur_name = nm;
    pc_q.push_back(e);
    if (flat < int'(TO)) begin
      m = '{we: 1'b0, sel: 1'b0, size: 2'b11, ir: 1'b1};
      mem_q.push_back(m);
    end
    if (dmem) begin
      m = '{we: dwe, sel: 1'b1, size: dsz, ir: 1'b0};
      mem_q.push_back(m);
    end
    age = 0; done = 0; cycles = 0; fcyc = 0; dcyc = 0;
    while (!done && cycles < 40) begin
      @(posedge clock);
      #1;
      if (cycles == 0) begin
        op_code = op; func3 = f3; read = rd; write = wr;
        external_call = ec; external_break = eb; branch_taken = tk;
      end
      cycles++;
      if (mem_req) begin
        if (mem_addr_sel) dcyc++;
        else fcyc++;
        mem_ready = (age == (mem_addr_sel ? dlat : flat));
        age = mem_ready ? 0 : age + 1;
      end else begin
        mem_ready = noise;
        age = 0;
      end
      #1;
      if (pc_write) done = 1;
    end
    chk({nm, ".completes"}, 32'(done), 32'd1);
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      chk({cur_name, ".stray_strobe"}, 32'((rf_write | csr_write | trap) & ~pc_write), 32'd0);
      if (pc_write) begin
        if (pc_q.size() == 0) begin
          chk({cur_name, ".unexpected_pc_write"}, 32'd1, 32'd0);
        end else begin
          mon_pc = pc_q.pop_front();
          chk({cur_name, ".retire"},
              32'({pc_sel, rf_write, rf_src, csr_write, trap, trap_cause, state}), 32'(mon_pc));
        end
      end
      if (mem_req && mem_ready) begin
        if (mem_q.size() == 0) begin
          chk({cur_name, ".unexpected_mem"}, 32'd1, 32'd0);
        end else begin
          mon_mem = mem_q.pop_front();
          chk({cur_name, ".mem"}, 32'({mem_we, mem_addr_sel, mem_size, ir_load}), 32'(mon_mem));
        end
      end
    end
  end

  initial begin
    int cy, fc, dc, n;
    mem_exp_t m;

    #2;
    chk("reset.state", 32'(state), 32'd0);
    chk("reset.strobes", 32'({mem_req, pc_write, ir_load, rf_write, trap}), 32'd0);
    chk("reset.cause", 32'(trap_cause), 32'd0);
    @(posedge clock);
    #1;
    chk("reset.held_no_req", 32'(mem_req), 32'd0);
    reset = 1'b0;
    #1;
    chk("release.no_req_before_edge", 32'(mem_req), 32'd0);

    run_instr("add", OpOp, 3'b000, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, ret(0, 1, 0, 0, 4),
              0, 0, 2'b00, cy, fc, dc);
    chk("add.cycles", 32'(cy), 32'd4);
    run_instr("add_idle_ready", OpOp, 3'b000, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1,
              ret(0, 1, 0, 0, 4), 0, 0, 2'b00, cy, fc, dc);
    chk("add_idle_ready.cycles", 32'(cy), 32'd4);
    run_instr("lw", OpLoad, 3'b010, 2'b11, 2'b00, 0, 0, 0, 0, 3, 0, ret(0, 1, 1, 0, 4),
              1, 0, 2'b11, cy, fc, dc);
    chk("lw.data_req_cycles", 32'(dc), 32'd4);
    run_instr("lb", OpLoad, 3'b000, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0, ret(0, 1, 1, 0, 4),
              1, 0, 2'b01, cy, fc, dc);
    run_instr("lh_slow_fetch", OpLoad, 3'b001, 2'b10, 2'b00, 0, 0, 0, 3, 0, 0,
              ret(0, 1, 1, 0, 4), 1, 0, 2'b10, cy, fc, dc);
    chk("lh_slow_fetch.fetch_cycles", 32'(fc), 32'd4);
    run_instr("sh", OpStore, 3'b001, 2'b00, 2'b10, 0, 0, 0, 0, 1, 0, ret(0, 0, 0, 0, 3),
              1, 1, 2'b10, cy, fc, dc);
    run_instr("sw", OpStore, 3'b010, 2'b00, 2'b11, 0, 0, 0, 0, 0, 0, ret(0, 0, 0, 0, 3),
              1, 1, 2'b11, cy, fc, dc);
    run_instr("beq_taken", OpBranch, 3'b000, 2'b00, 2'b00, 0, 0, 1, 0, 0, 0,
              ret(1, 0, 0, 0, 2), 0, 0, 2'b00, cy, fc, dc);
    chk("beq_taken.cycles", 32'(cy), 32'd3);
    run_instr("bne_not_taken", OpBranch, 3'b001, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0,
              ret(0, 0, 0, 0, 2), 0, 0, 2'b00, cy, fc, dc);
    run_instr("jal", OpJal, 3'b000, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, ret(1, 1, 2, 0, 4),
              0, 0, 2'b00, cy, fc, dc);
    run_instr("jalr", OpJalr, 3'b000, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, ret(1, 1, 2, 0, 4),
              0, 0, 2'b00, cy, fc, dc);
    run_instr("csrrw", OpSystem, 3'b001, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, ret(0, 1, 3, 1, 4),
              0, 0, 2'b00, cy, fc, dc);
    run_instr("csrrsi", OpSystem, 3'b110, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0,
              ret(0, 1, 3, 1, 4), 0, 0, 2'b00, cy, fc, dc);
    run_instr("lui", OpLui, 3'b000, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, ret(0, 1, 0, 0, 4),
              0, 0, 2'b00, cy, fc, dc);
    run_instr("auipc", OpAuipc, 3'b000, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, ret(0, 1, 0, 0, 4),
              0, 0, 2'b00, cy, fc, dc);
    run_instr("addi", OpOpImm, 3'b000, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, ret(0, 1, 0, 0, 4),
              0, 0, 2'b00, cy, fc, dc);
    run_instr("fence", OpFence, 3'b000, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, ret(0, 0, 0, 0, 2),
              0, 0, 2'b00, cy, fc, dc);
    run_instr("ecall", OpSystem, 3'b000, 2'b00, 2'b00, 1, 0, 0, 0, 0, 0, trp(CauseEcall),
              0, 0, 2'b00, cy, fc, dc);
    run_instr("add_cause_held", OpOp, 3'b000, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0,
              ret(0, 1, 0, 0, 4), 0, 0, 2'b00, cy, fc, dc);
    run_instr("ebreak", OpSystem, 3'b000, 2'b00, 2'b00, 0, 1, 0, 0, 0, 0, trp(CauseEbreak),
              0, 0, 2'b00, cy, fc, dc);
    run_instr("illegal_op", 7'b1111111, 3'b000, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0,
              trp(CauseIllegal), 0, 0, 2'b00, cy, fc, dc);
    run_instr("load_size0", OpLoad, 3'b010, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0,
              trp(CauseIllegal), 0, 0, 2'b00, cy, fc, dc);
    run_instr("store_size0", OpStore, 3'b010, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0,
              trp(CauseIllegal), 0, 0, 2'b00, cy, fc, dc);
    run_instr("system_f3_100", OpSystem, 3'b100, 2'b00, 2'b00, 1, 0, 0, 0, 0, 0,
              trp(CauseIllegal), 0, 0, 2'b00, cy, fc, dc);
    run_instr("fetch_timeout", OpOp, 3'b000, 2'b00, 2'b00, 0, 0, 0, 4, 0, 0, trp(CauseBus),
              0, 0, 2'b00, cy, fc, dc);
    chk("fetch_timeout.wait_cycles", 32'(fc), 32'd4);
    run_instr("mem_timeout", OpLoad, 3'b010, 2'b11, 2'b00, 0, 0, 0, 0, 4, 0, trp(CauseBus),
              0, 0, 2'b00, cy, fc, dc);
    chk("mem_timeout.wait_cycles", 32'(dc), 32'd4);

    // Store interrupted by reset while its data access is outstanding.
    cur_name = "reset_store";
    m = '{we: 1'b0, sel: 1'b0, size: 2'b11, ir: 1'b1};
    mem_q.push_back(m);
    @(posedge clock);
    #1;
    op_code = OpStore; func3 = 3'b010; write = 2'b11; read = 2'b00;
    external_call = 0; external_break = 0;
    mem_ready = 1'b1;
    n = 0;
    do begin
      @(posedge clock);
      #1;
      mem_ready = 1'b0;
      n++;
    end while (state != 3'd3 && n < 10);
    chk("reset_store.reach_mem", 32'(state), 32'd3);
    chk("reset_store.we_in_mem", 32'(mem_we), 32'd1);
    reset = 1'b1;
    #1;
    chk("reset_store.state_in_reset", 32'(state), 32'd0);
    chk("reset_store.strobes_in_reset", 32'({mem_req, mem_we, pc_write, trap}), 32'd0);
    chk("reset_store.cause_cleared", 32'(trap_cause), 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    chk("reset_store.after_state", 32'(state), 32'd0);
    chk("reset_store.after_we", 32'(mem_we), 32'd0);
    hc = 2'd0;
    run_instr("add_after_reset", OpOp, 3'b000, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0,
              ret(0, 1, 0, 0, 4), 0, 0, 2'b00, cy, fc, dc);
    chk("add_after_reset.cycles", 32'(cy), 32'd4);

    @(negedge clock);
    #1;
    chk("end.pc_queue_empty", 32'(pc_q.size()), 32'd0);
    chk("end.mem_queue_empty", 32'(mem_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 Parameter MEM_TIMEOUT, default 255: maximum wait cycles for mem_ready before a bus-error trap.
REQ-002 clock  in  1  system clock, rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 op_code  in  7  opcode field from instruction_decoder.
REQ-005 func3  in  3  func3 field from instruction_decoder.
REQ-006 read  in  2  load size from decoder: 01 byte, 10 half, 11 word, 00 none/illegal.
REQ-007 write  in  2  store size from decoder, same encoding as read.
REQ-008 external_call, external_break  in  1 each  ECALL / EBREAK decode flags.
REQ-009 branch_taken  in  1  ALU branch-compare result, valid in EXECUTE.
REQ-010 mem_ready  in  1  memory completes the current request this cycle.
REQ-011 mem_req  out  1  memory request, held until mem_ready.
REQ-012 mem_we  out  1  write request; mem_size  out  2  access size, read/write encoding.
REQ-013 mem_addr_sel  out  1  0 = PC, 1 = ALU result.
REQ-014 ir_load  out  1  latch fetched instruction.
REQ-015 pc_write  out  1  PC update strobe; pc_sel  out  2  0 = PC+4, 1 = branch/jump target, 2 = trap vector.
REQ-016 rf_write  out  1  register write; rf_src  out  2  0 = ALU, 1 = memory, 2 = PC+4, 3 = CSR.
REQ-017 csr_write  out  1  CSR write-back strobe.
REQ-018 trap  out  1  one-cycle trap pulse; trap_cause  out  2  0 illegal, 1 ecall, 2 ebreak, 3 bus error.
REQ-019 state  out  3  current state, for debug.

Function
REQ-020 States FETCH, DECODE, EXECUTE, MEM, WRITEBACK, TRAP; all outputs registered-state Moore decodes except where noted.
REQ-021 FETCH: mem_req=1, mem_we=0, mem_addr_sel=0, mem_size=11; on mem_ready assert ir_load same cycle, go DECODE; else stay.
REQ-022 DECODE: one cycle, no strobes; classify opcode; go EXECUTE.
REQ-023 EXECUTE, BRANCH (1100011): pc_write=1, pc_sel=branch_taken?1:0, go FETCH.
REQ-024 EXECUTE, LOAD (0000011) with read!=00 or STORE (0100011) with write!=00: go MEM.
REQ-025 EXECUTE, OP, OP-IMM, LUI, AUIPC, JAL, JALR, CSR-type SYSTEM (func3!=000): go WRITEBACK.
REQ-026 EXECUTE, FENCE (0001111): pc_write=1, pc_sel=0, go FETCH.
REQ-027 EXECUTE, SYSTEM func3=000: external_call -> TRAP cause 1; external_break -> TRAP cause 2; neither -> cause 0.
REQ-028 EXECUTE, any other opcode, LOAD with read=00, STORE with write=00, or func3=100 on SYSTEM: TRAP cause 0.
REQ-029 MEM: mem_req=1, mem_addr_sel=1, mem_we=1 for store, mem_size from read/write; on mem_ready: load -> WRITEBACK, store -> pc_write=1, pc_sel=0, go FETCH.
REQ-030 WRITEBACK: rf_write=1 one cycle; rf_src 1 load, 2 JAL/JALR, 3 CSR, else 0; csr_write=1 for CSR-type; pc_write=1, pc_sel=1 for JAL/JALR else 0; go FETCH.
REQ-031 Wait counter clears on entry to FETCH/MEM, increments each cycle mem_ready=0; when count reaches MEM_TIMEOUT without mem_ready, drop mem_req, go TRAP cause 3.
REQ-032 mem_ready on the timeout cycle wins: normal completion, no trap.
REQ-033 TRAP: trap=1, pc_write=1, pc_sel=2, one cycle, go FETCH; trap_cause held stable until next trap.
REQ-034 mem_ready outside FETCH/MEM is ignored.
REQ-035 Exactly one pc_write per retired or trapped instruction.

Reset
REQ-036 reset asserted: state=FETCH immediately, counter=0, trap_cause=0, all strobes 0; mid-transaction reset abandons the access.
REQ-037 First mem_req asserts on the first clock edge after reset deasserts.

Structure
REQ-038 Shared package cpu_pkg holds the state enum, opcode constants, pc_sel/rf_src/trap_cause encodings.
REQ-039 Single module; wait counter inline, width $clog2(MEM_TIMEOUT+1).

Verification
REQ-040 ADD (op 0110011), mem_ready immediate -> FETCH,DECODE,EXECUTE,WRITEBACK; rf_write=1, rf_src=0, pc_sel=0 in cycle 4.
REQ-041 LW (read=11), data mem_ready after 3 cycles -> MEM holds mem_req 4 cycles, mem_size=11, then rf_src=1.
REQ-042 BEQ, branch_taken=1 -> pc_write=1, pc_sel=1 in EXECUTE, no rf_write.
REQ-043 ECALL (op 1110011, func3 000, external_call=1) -> trap=1, trap_cause=1, pc_sel=2.
REQ-044 MEM_TIMEOUT=4, mem_ready held 0 in FETCH -> trap cause 3 after 4 wait cycles; mem_ready on cycle 4 -> no trap.
REQ-045 reset pulsed during MEM of a store -> strobes 0, next cycle state=FETCH, mem_we=0.
